fir_mac_sequencer: RTL and testbench



---
 rtl/fir_ctrl_pkg.sv | 17 +
 rtl/fir_circ_ptr.sv | 38 +++
 rtl/fir_mac_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the time-multiplexed FIR control path.
package fir_ctrl_pkg;

   typedef enum logic [2:0] {FLUSH, IDLE, RUN, DRAIN, DONE} state_t;

   localparam int DEF_NUM_TAPS = 317;
   localparam int DEF_MAC_LAT  = 3;

   // Smallest width w with 2**w >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/fir_circ_ptr.sv
// Modulo-NUM_TAPS pointer: load has priority, then increment, then decrement.
module fir_circ_ptr #(
   parameter int NUM_TAPS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] ptr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

   logic [ADDR_W-1:0] ptr_reg, ptr_next;

   always_comb begin
      ptr_next = ptr_reg;
      if (load)
         ptr_next = load_val;
      else if (inc)
         ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
      else if (dec)
         ptr_next = (ptr_reg == '0) ? LAST : ptr_reg - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_reg <= '0;
      else
         ptr_reg <= ptr_next;
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a single-MAC FIR: flushes the delay line, then walks every tap
// once per accepted sample and pulses y_latch when the accumulator has settled.
module fir_mac_sequencer
   import fir_ctrl_pkg::*;
#(
   parameter int NUM_TAPS = DEF_NUM_TAPS,
   parameter int ADDR_W   = clog2(NUM_TAPS),
   parameter int MAC_LAT  = DEF_MAC_LAT
) (
   input  logic              sys_clk_100,
   input  logic              rst,
   input  logic              x_valid,
   output logic              x_ready,
   output logic              dl_we,
   output logic              dl_wr_zero,
   output logic [ADDR_W-1:0] dl_wr_addr,
   output logic [ADDR_W-1:0] dl_rd_addr,
   output logic [ADDR_W-1:0] coef_addr,
   output logic              mac_en,
   output logic              acc_clr,
   output logic              y_latch,
   output logic              busy,
   output logic              overrun,
   input  logic              overrun_clr
);

   // One extra bit so the flush counter can reach NUM_TAPS itself.
   localparam int                CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0]  FLUSH_END = CNT_W'(NUM_TAPS);
   localparam logic [CNT_W-1:0]  DRAIN_END = CNT_W'(MAC_LAT - 1);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-1:0] coef_reg, coef_next;
   logic [ADDR_W-1:0] flush_addr_reg, flush_addr_next;
   logic              flush_we_reg, flush_we_next;
   logic              mac_en_reg, mac_en_next;
   logic              acc_clr_reg, acc_clr_next;
   logic              y_latch_reg, y_latch_next;
   logic              busy_reg, busy_next;
   logic              overrun_reg, overrun_next;
   logic              wr_inc, rd_load, rd_dec;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;

   fir_circ_ptr #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W)) u_wr_ptr (
      .clk      (sys_clk_100),
      .rst_n    (rst),
      .load     (1'b0),
      .load_val ('0),
      .inc      (wr_inc),
      .dec      (1'b0),
      .ptr      (wr_ptr)
   );

   fir_circ_ptr #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W)) u_rd_ptr (
      .clk      (sys_clk_100),
      .rst_n    (rst),
      .load     (rd_load),
      .load_val (wr_ptr),
      .inc      (1'b0),
      .dec      (rd_dec),
      .ptr      (rd_ptr)
   );

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      coef_next       = coef_reg;
      flush_addr_next = flush_addr_reg;
      flush_we_next   = 1'b0;
      mac_en_next     = 1'b0;
      acc_clr_next    = 1'b0;
      y_latch_next    = 1'b0;
      wr_inc          = 1'b0;
      rd_load         = 1'b0;
      rd_dec          = 1'b0;
      case (state_reg)
         FLUSH: begin
            if (cnt_reg == FLUSH_END) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               flush_we_next   = 1'b1;
               flush_addr_next = cnt_reg[ADDR_W-1:0];
               cnt_next        = cnt_reg + 1'b1;
            end
         end
         IDLE: begin
            if (x_valid) begin
               state_next   = RUN;
               rd_load      = 1'b1;
               coef_next    = '0;
               mac_en_next  = 1'b1;
               acc_clr_next = 1'b1;
            end
         end
         RUN: begin
            // Pointers freeze on the last tap so DRAIN shows its addresses.
            if (coef_reg == LAST_TAP) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end else begin
               mac_en_next = 1'b1;
               coef_next   = coef_reg + 1'b1;
               rd_dec      = 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_reg == DRAIN_END) begin
               state_next   = DONE;
               y_latch_next = 1'b1;
               cnt_next     = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
            wr_inc     = 1'b1;
         end
         default: state_next = FLUSH;
      endcase
      busy_next    = (state_next != IDLE);
      overrun_next = (x_valid & ~x_ready) | (overrun_reg & ~overrun_clr);
   end

   always_ff @(posedge sys_clk_100 or negedge rst) begin
      if (!rst) begin
         state_reg      <= FLUSH;
         cnt_reg        <= '0;
         coef_reg       <= '0;
         flush_addr_reg <= '0;
         flush_we_reg   <= 1'b0;
         mac_en_reg     <= 1'b0;
         acc_clr_reg    <= 1'b0;
         y_latch_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         coef_reg       <= coef_next;
         flush_addr_reg <= flush_addr_next;
         flush_we_reg   <= flush_we_next;
         mac_en_reg     <= mac_en_next;
         acc_clr_reg    <= acc_clr_next;
         y_latch_reg    <= y_latch_next;
         busy_reg       <= busy_next;
         overrun_reg    <= overrun_next;
      end
   end

   assign x_ready    = (state_reg == IDLE);
   assign dl_we      = x_ready ? x_valid : flush_we_reg;
   assign dl_wr_zero = flush_we_reg;
   assign dl_wr_addr = (state_reg == FLUSH) ? flush_addr_reg : wr_ptr;
   assign dl_rd_addr = rd_ptr;
   assign coef_addr  = coef_reg;
   assign mac_en     = mac_en_reg;
   assign acc_clr    = acc_clr_reg;
   assign y_latch    = y_latch_reg;
   assign busy       = busy_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: two configurations (317/3 and 8/1) run side by side on one clock.
module tb_fir_mac_sequencer;

   typedef struct {
      int t;
      int base;
      int idx;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs != exp) begin
         fail_cnt++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
         localparam int N       = (gi == 0) ? 317 : 8;
         localparam int L       = (gi == 0) ? 3 : 1;
         localparam int AW      = fir_ctrl_pkg::clog2(N);
         localparam int NSAMP   = (gi == 0) ? 6 : 20;
         localparam int OVR_AT  = (N > 100) ? 100 : 2;
         localparam int RST_AT  = (N > 150) ? 150 : 4;

         logic          rst_n       = 1'b0;
         logic          x_valid     = 1'b0;
         logic          overrun_clr = 1'b0;
         logic          x_ready, dl_we, dl_wr_zero, mac_en, acc_clr;
         logic          y_latch, busy, overrun;
         logic [AW-1:0] dl_wr_addr, dl_rd_addr, coef_addr;

         exp_t q[$];
         bit   mon_on   = 1'b0;
         bit   fin      = 1'b0;
         int   model_wp = 0;
         int   prev_t   = -1;

         fir_mac_sequencer #(.NUM_TAPS(N), .ADDR_W(AW), .MAC_LAT(L)) u_dut (
            .sys_clk_100 (clk),
            .rst         (rst_n),
            .x_valid     (x_valid),
            .x_ready     (x_ready),
            .dl_we       (dl_we),
            .dl_wr_zero  (dl_wr_zero),
            .dl_wr_addr  (dl_wr_addr),
            .dl_rd_addr  (dl_rd_addr),
            .coef_addr   (coef_addr),
            .mac_en      (mac_en),
            .acc_clr     (acc_clr),
            .y_latch     (y_latch),
            .busy        (busy),
            .overrun     (overrun),
            .overrun_clr (overrun_clr)
         );

         function automatic string tg(input string s);
            return $sformatf("c%0d.%s", gi, s);
         endfunction

         task automatic check_all_zero();
            check_eq(tg("rst_flags"), int'({x_ready, dl_we, dl_wr_zero, mac_en, acc_clr,
                                            y_latch, busy, overrun}), 0);
            check_eq(tg("rst_addrs"), int'(dl_wr_addr | dl_rd_addr | coef_addr), 0);
         endtask

         // Called just after reset release; optionally pokes x_valid mid-flush.
         task automatic do_flush(input bit poke);
            for (int i = 0; i < N; i++) begin
               @(posedge clk); #1;
               x_valid = poke && (i == 2);
               check_eq(tg("fl_flags"), int'({dl_we, dl_wr_zero, x_ready, busy, mac_en, y_latch}),
                        int'(6'b110100));
               check_eq(tg("fl_addr"), int'(dl_wr_addr), i);
            end
            @(posedge clk); #1;
            x_valid = 1'b0;
            check_eq(tg("fl_end"), int'({dl_we, dl_wr_zero, x_ready, busy}), int'(4'b0010));
            check_eq(tg("fl_ovr"), int'(overrun), int'(poke));
            if (poke) begin
               overrun_clr = 1'b1;
               @(posedge clk); #1;
               overrun_clr = 1'b0;
               check_eq(tg("fl_ovr_clr"), int'(overrun), 0);
            end
            mon_on = 1'b1;
         endtask

         task automatic send(input int idx, input bit hold2, output int t);
            int guard;
            guard = 0;
            while (!x_ready && guard < 2 * (N + L + 4)) begin
               @(posedge clk); #1;
               guard++;
            end
            check_eq(tg("ready_to"), int'(x_ready), 1);
            if (prev_t >= 0) check_eq(tg("ready_lat"), cyc - prev_t, N + L + 2);
            x_valid = 1'b1;
            #1;
            check_eq(tg("wr_we"), int'(dl_we), 1);
            check_eq(tg("wr_addr"), int'(dl_wr_addr), model_wp);
            t = cyc;
            q.push_back('{t, model_wp, idx});
            model_wp = (model_wp + 1) % N;
            prev_t = t;
            @(posedge clk); #1;
            if (hold2) begin
               check_eq(tg("hold_ready"), int'(x_ready), 0);
               check_eq(tg("hold_we"), int'(dl_we), 0);
               @(posedge clk); #1;
            end
            x_valid = 1'b0;
         endtask

         initial begin : drv
            int t;
            int guard;
            repeat (3) @(posedge clk);
            #1;
            check_all_zero();
            rst_n = 1'b1;
            do_flush(1'b0);
            for (int idx = 0; idx < NSAMP; idx++) begin
               send(idx, idx == 1, t);
               if (idx == 1) begin
                  check_eq(tg("hold_ovr"), int'(overrun), 1);
                  overrun_clr = 1'b1;
                  @(posedge clk); #1;
                  overrun_clr = 1'b0;
                  check_eq(tg("hold_ovr_clr"), int'(overrun), 0);
               end
               if (idx == 2) begin
                  while (cyc < t + OVR_AT) begin @(posedge clk); #1; end
                  check_eq(tg("ovr_pre"), int'(overrun), 0);
                  x_valid = 1'b1;
                  check_eq(tg("ovr_ready"), int'(x_ready), 0);
                  @(posedge clk); #1;
                  check_eq(tg("ovr_set"), int'(overrun), 1);
                  overrun_clr = 1'b1;
                  @(posedge clk); #1;
                  x_valid = 1'b0;
                  check_eq(tg("ovr_set_wins"), int'(overrun), 1);
                  @(posedge clk); #1;
                  overrun_clr = 1'b0;
                  check_eq(tg("ovr_clr"), int'(overrun), 0);
               end
               if (idx == 3) begin
                  while (cyc < t + RST_AT) begin @(posedge clk); #1; end
                  mon_on = 1'b0;
                  q.delete();
                  rst_n = 1'b0;
                  #1;
                  check_all_zero();
                  repeat (2) @(posedge clk);
                  #1;
                  check_all_zero();
                  rst_n = 1'b1;
                  model_wp = 0;
                  prev_t = -1;
                  do_flush(1'b1);
               end
            end
            guard = 0;
            while (q.size() > 0 && guard < 2 * (N + L + 4)) begin
               @(posedge clk); #1;
               guard++;
            end
            check_eq(tg("q_empty"), q.size(), 0);
            fin = 1'b1;
         end

         always @(negedge clk) begin : mon
            int k;
            if (mon_on && rst_n) begin
               if (q.size() > 0) begin
                  k = cyc - q[0].t - 1;
                  if (k >= 0 && k < N) begin
                     check_eq(tg("mac_en"), int'(mac_en), 1);
                     check_eq(tg("coef"), int'(coef_addr), k);
                     check_eq(tg("rd"), int'(dl_rd_addr), ((q[0].base - k) % N + N) % N);
                     check_eq(tg("acc_clr"), int'(acc_clr), int'(k == 0));
                  end else begin
                     check_eq(tg("mac_off"), int'(mac_en), 0);
                     if (k >= N) begin
                        check_eq(tg("coef_hold"), int'(coef_addr), N - 1);
                        check_eq(tg("rd_hold"), int'(dl_rd_addr), (q[0].base + 1) % N);
                     end
                  end
                  if (k >= 0) begin
                     check_eq(tg("busy"), int'(busy), 1);
                     check_eq(tg("no_we"), int'(dl_we), 0);
                  end
                  if (cyc == q[0].t + N + L + 1) begin
                     check_eq(tg("y_latch"), int'(y_latch), 1);
                     $display("c%0d sample %0d base=%0d y_latch at T+%0d",
                              gi, q[0].idx, q[0].base, cyc - q[0].t);
                     void'(q.pop_front());
                  end else begin
                     check_eq(tg("y_quiet"), int'(y_latch), 0);
                  end
               end else begin
                  check_eq(tg("idle_mac"), int'(mac_en), 0);
                  check_eq(tg("idle_y"), int'(y_latch), 0);
               end
            end
         end
      end
   endgenerate

   initial begin : summary
      int g;
      g = 0;
      while (!(g_cfg[0].fin && g_cfg[1].fin) && g < 50000) begin
         @(posedge clk);
         g++;
      end
      check_eq("all_done", int'({g_cfg[1].fin, g_cfg[0].fin}), 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
